// File: rtl/cpu_led_display.sv
// cpu_led_display: buffers CPU result bytes in a FIFO and shows each as high nibble, low nibble, blank gap on the LEDs
module cpu_led_display #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] result_in,
  input  logic       result_valid,
  output logic       result_ready,
  output logic [3:0] led_out,
  output logic       led_phase,
  output logic       busy,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int MX = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, SHOW_HI, SHOW_LO, GAP} state_t;
  state_t state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [CW-1:0] hold;
  logic [7:0] disp;
  logic push, pop, done, fin;
  assign result_ready = cnt != (AW+1)'(FIFO_DEPTH);
  assign push = result_valid && result_ready;
  assign done = hold == '0;
  assign fin = done && (state == GAP || (GAP_CYCLES == 0 && state == SHOW_LO));
  assign pop = cnt != '0 && (state == IDLE || fin);
  assign led_out = state == SHOW_HI ? disp[7:4] : state == SHOW_LO ? disp[3:0] : 4'h0;
  assign led_phase = state == SHOW_HI;
  assign busy = state != IDLE || cnt != '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= result_in;
  always_ff @(posedge clk)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      state <= IDLE;
      hold <= '0;
      disp <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp <= rp + 1'b1;
        disp <= mem[rp];
      end
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (result_valid && !result_ready) overflow <= 1'b1;
      if (pop) begin
        state <= SHOW_HI;
        hold <= HOLD_LD;
      end else if (fin || state == IDLE) state <= IDLE;
      else if (!done) hold <= hold - 1'b1;
      else if (state == SHOW_HI) begin
        state <= SHOW_LO;
        hold <= HOLD_LD;
      end else begin
        state <= GAP;
        hold <= GAP_LD;
      end
    end
endmodule

// File: tb/tb_cpu_led_display.sv
// tb_cpu_led_display: directed scoreboard bench for the default build and a GAP_CYCLES=0 build
module tb_cpu_led_display;
  logic clk = 0, reset = 0, result_valid = 0;
  logic [7:0] result_in = 0;
  logic result_ready, led_phase, busy, overflow;
  logic [3:0] led_out;
  logic rdy0, ph0, bz0, ov0;
  logic [3:0] led0;
  int edges = 0, t0 = 0, checks = 0, errors = 0;
  typedef struct { int at; bit sel; logic [7:0] v; string name; } exp_t;
  exp_t q[$];
  exp_t x;
  logic [7:0] got;
  cpu_led_display dut (
    .clk(clk), .reset(reset), .result_in(result_in), .result_valid(result_valid),
    .result_ready(result_ready), .led_out(led_out), .led_phase(led_phase),
    .busy(busy), .overflow(overflow)
  );
  cpu_led_display #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .result_in(result_in), .result_valid(result_valid),
    .result_ready(rdy0), .led_out(led0), .led_phase(ph0),
    .busy(bz0), .overflow(ov0)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;
  always @(negedge clk)
    while (q.size() > 0 && q[0].at <= edges) begin
      x = q.pop_front();
      got = x.sel ? {led0, ph0, bz0, ov0, rdy0} : {led_out, led_phase, busy, overflow, result_ready};
      checks++;
      if (x.at < edges || got !== x.v) begin
        errors++;
        $display("FAIL %s: got led=%h phase=%b busy=%b ovf=%b ready=%b, expected led=%h phase=%b busy=%b ovf=%b ready=%b (due %0d, now %0d)",
                 x.name, got[7:4], got[3], got[2], got[1], got[0],
                 x.v[7:4], x.v[3], x.v[2], x.v[1], x.v[0], x.at, edges);
      end
    end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic e(input int k, input bit s, input logic [3:0] l, input bit p, input bit b,
                   input bit o, input bit r, input string n);
    q.push_back('{t0 + k, s, {l, p, b, o, r}, n});
  endtask
  task automatic drv(input bit v, input logic [7:0] d);
    result_valid = v;
    result_in = d;
    tick();
  endtask
  initial begin
    tick(3);
    reset = 1;
    t0 = edges;
    e(0, 0, 4'h0, 0, 0, 0, 1, "reset_state");
    e(1, 0, 4'h0, 0, 1, 0, 1, "single_pushed");
    e(2, 0, 4'hA, 1, 1, 0, 1, "single_hi_first");
    e(5, 0, 4'hA, 1, 1, 0, 1, "single_hi_last");
    e(6, 0, 4'h5, 0, 1, 0, 1, "single_lo_first");
    e(9, 0, 4'h5, 0, 1, 0, 1, "single_lo_last");
    e(10, 0, 4'h0, 0, 1, 0, 1, "single_gap_first");
    e(11, 0, 4'h0, 0, 1, 0, 1, "single_gap_last");
    e(12, 0, 4'h0, 0, 0, 0, 1, "single_idle");
    drv(1, 8'hA5);
    result_valid = 0;
    tick(14);
    t0 = edges;
    e(2, 0, 4'h1, 1, 1, 0, 1, "b2b_hi1_first");
    e(5, 0, 4'h1, 1, 1, 0, 1, "b2b_hi1_last");
    e(6, 0, 4'h2, 0, 1, 0, 1, "b2b_lo1_first");
    e(9, 0, 4'h2, 0, 1, 0, 1, "b2b_lo1_last");
    e(10, 0, 4'h0, 0, 1, 0, 1, "b2b_gap1_first");
    e(11, 0, 4'h0, 0, 1, 0, 1, "b2b_gap1_last");
    e(12, 0, 4'h3, 1, 1, 0, 1, "b2b_hi2_first");
    e(15, 0, 4'h3, 1, 1, 0, 1, "b2b_hi2_last");
    e(16, 0, 4'h4, 0, 1, 0, 1, "b2b_lo2_first");
    e(19, 0, 4'h4, 0, 1, 0, 1, "b2b_lo2_last");
    e(21, 0, 4'h0, 0, 1, 0, 1, "b2b_gap2_last");
    e(22, 0, 4'h0, 0, 0, 0, 1, "b2b_idle");
    drv(1, 8'h12);
    drv(1, 8'h34);
    result_valid = 0;
    tick(22);
    t0 = edges;
    e(5, 0, 4'h0, 1, 1, 0, 0, "ovf_full_not_ready");
    e(6, 0, 4'h1, 0, 1, 1, 0, "ovf_sticky_set");
    e(11, 0, 4'h0, 0, 1, 1, 0, "ovf_still_full");
    e(12, 0, 4'h0, 1, 1, 1, 1, "ovf_slot_freed");
    e(16, 0, 4'h2, 0, 1, 1, 1, "ovf_byte2");
    e(26, 0, 4'h3, 0, 1, 1, 1, "ovf_byte3");
    e(36, 0, 4'h4, 0, 1, 1, 1, "ovf_byte4");
    e(46, 0, 4'h5, 0, 1, 1, 1, "ovf_byte5");
    e(52, 0, 4'h0, 0, 0, 1, 1, "ovf_no_sixth");
    for (int i = 1; i <= 6; i++) drv(1, 8'(i));
    result_valid = 0;
    tick(48);
    t0 = edges;
    e(6, 0, 4'h9, 0, 1, 1, 1, "rst_before");
    e(8, 0, 4'h0, 0, 0, 0, 1, "rst_cleared");
    e(9, 0, 4'h0, 0, 0, 0, 1, "rst_buffer_dropped");
    e(10, 0, 4'h0, 0, 1, 0, 1, "rst_7e_pushed");
    e(11, 0, 4'h7, 1, 1, 0, 1, "rst_7e_hi_first");
    e(14, 0, 4'h7, 1, 1, 0, 1, "rst_7e_hi_last");
    e(15, 0, 4'hE, 0, 1, 0, 1, "rst_7e_lo_first");
    e(18, 0, 4'hE, 0, 1, 0, 1, "rst_7e_lo_last");
    e(19, 0, 4'h0, 0, 1, 0, 1, "rst_7e_gap");
    e(21, 0, 4'h0, 0, 0, 0, 1, "rst_7e_idle");
    drv(1, 8'h99);
    drv(1, 8'h88);
    result_valid = 0;
    tick(5);
    reset = 0;
    tick();
    reset = 1;
    tick();
    drv(1, 8'h7E);
    result_valid = 0;
    tick(13);
    t0 = edges;
    e(2, 1, 4'hC, 1, 1, 0, 1, "gap0_hi1");
    e(9, 1, 4'h3, 0, 1, 0, 1, "gap0_lo1_last");
    e(10, 1, 4'h5, 1, 1, 0, 1, "gap0_hi2_no_gap");
    e(13, 1, 4'h5, 1, 1, 0, 1, "gap0_hi2_last");
    e(14, 1, 4'hA, 0, 1, 0, 1, "gap0_lo2_first");
    e(17, 1, 4'hA, 0, 1, 0, 1, "gap0_lo2_last");
    e(18, 1, 4'h0, 0, 0, 0, 1, "gap0_idle");
    drv(1, 8'hC3);
    drv(1, 8'h5A);
    result_valid = 0;
    tick(24);
    t0 = edges;
    e(1, 0, 4'h0, 0, 1, 0, 1, "zero_busy_start");
    e(2, 0, 4'h0, 1, 1, 0, 1, "zero_hi");
    e(6, 0, 4'h0, 0, 1, 0, 1, "zero_lo");
    e(11, 0, 4'h0, 0, 1, 0, 1, "zero_gap_end");
    e(12, 0, 4'h0, 0, 0, 0, 1, "zero_idle");
    drv(1, 8'h00);
    result_valid = 0;
    tick(13);
    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d expectations never checked, required 0", q.size());
      errors += q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_led_display.md
Name: cpu_led_display

Overview:
Downstream consumer of the CPU core's 8-bit result bus. Buffers each result byte in a small FIFO and presents it on the 4 board LEDs one nibble at a time: high nibble, then low nibble, then a blank gap. A slow human-visible display therefore never stalls the CPU. Replaces the direct low-nibble LED tap; the board top instantiates it between the CPU core and the LED pins.

Parameters:
HOLD_CYCLES, 4, clock cycles each nibble stays on the LEDs (>=1; board build overrides to about 0.5 s)
GAP_CYCLES, 2, blank cycles (led_out=0) after the low nibble (0 = no gap)
FIFO_DEPTH, 4, result bytes buffered (power of 2, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-low reset; sampled on the clk rising edge, 0 = reset
result_in  input  8  result byte from CPU core
result_valid  input  1  result_in valid this cycle
result_ready  output  1  FIFO can accept; = not full
led_out  output  4  nibble currently displayed
led_phase  output  1  1 while high nibble shown, else 0
busy  output  1  1 when state != IDLE or FIFO non-empty
overflow  output  1  sticky: a valid byte was dropped because FIFO full

Behaviour:
- Reset (reset==0 at a clk edge):
  - FIFO emptied; state=IDLE; counters cleared.
  - led_out=0, led_phase=0, busy=0, overflow=0, result_ready=1, effective next cycle.
  - Applies mid-display: the in-flight byte and buffered bytes are discarded.
- Push:
  - Occurs on result_valid && result_ready; the byte is written at that edge.
  - If result_valid && !result_ready, the byte is dropped and overflow sets next cycle. overflow clears only on reset.
  - The CPU never stalls.
- result_ready is computed from the registered FIFO count only. A pop in the same cycle does not free a slot for a push in that cycle.
- Pop: one byte is moved into the display register in one of two cases:
  - In IDLE when the FIFO is non-empty.
  - On the final cycle of GAP when the FIFO is non-empty.
  - If GAP_CYCLES=0, the final cycle of SHOW_LO is used instead.
- FSM states: IDLE, SHOW_HI, SHOW_LO, GAP.
  - IDLE: led_out=0. If non-empty: pop, next state SHOW_HI.
  - SHOW_HI: led_out=byte[7:4], led_phase=1. Lasts exactly HOLD_CYCLES cycles, then SHOW_LO.
  - SHOW_LO: led_out=byte[3:0]. Lasts exactly HOLD_CYCLES cycles, then GAP. If GAP_CYCLES=0, it exits like the end of GAP.
  - GAP: led_out=0. Lasts exactly GAP_CYCLES cycles. On exit: if the FIFO is non-empty, pop and go to SHOW_HI; else go to IDLE.
- Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. SHOW_HI is visible from cycle N+2.
- Hold counter: width clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). Load value-1 on state entry, decrement, transition at 0. No wrap beyond the load.
- FIFO:
  - Circular buffer with read and write pointers plus a count.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop when neither full nor empty leaves count unchanged.
- Byte value 0x00 is displayed like any other: busy=1 for the full sequence even though led_out stays 0.
- All outputs are registered or derived from registered state only; no combinational path from result_* to led_*.

Test Plan:
(HOLD_CYCLES=4, GAP_CYCLES=2, FIFO_DEPTH=4; cycle 0 = first edge with reset=1)
- Single byte: push 0xA5 at cycle 0 -> led_out=0xA with led_phase=1 on cycles 2-5; 0x5 on cycles 6-9; 0x0 on cycles 10-11; IDLE with busy=0 from cycle 12.
- Back-to-back: push 0x12 at cycle 0 and 0x34 at cycle 1 -> 0x1 on 2-5, 0x2 on 6-9, gap on 10-11 (pop at 11), 0x3 on 12-15, 0x4 on 16-19; busy=0 from cycle 22.
- Overflow: valid held high for cycles 0-5 with bytes 0x01..0x06 -> byte 0x01 popped at cycle 1; FIFO full after cycle 4; result_ready=0 at cycle 5; 0x06 dropped; overflow=1 from cycle 6. Display sequence is 1,2,3,4,5 with no 6.
- Reset mid-operation: after the overflow test, drive reset=0 for one cycle during SHOW_LO -> next cycle led_out=0, led_phase=0, busy=0, overflow=0, result_ready=1. A subsequent push of 0x7E displays normally with 2-cycle latency.
- GAP_CYCLES=0 build: push 0xC3 and 0x5A on consecutive cycles -> 0x3 on cycles 6-9 followed immediately by 0x5 on cycles 10-13 with no blank cycle.
- Zero byte: push 0x00 -> led_out=0 throughout, busy=1 on cycles 1-11, busy=0 at cycle 12.
